// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the uart_rx_fifo receiver slice.
//   FSM state encodings (IDLE, START, DATA, PARITY, STOP),
//   MIN_DIV     smallest usable clocks-per-bit value,
//   SYNC_STAGES depth of the rx_data synchroniser.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side handshake of the receive FIFO.
//   data_out    FIFO head word (first-word fall-through)
//   data_valid  FIFO not empty
//   data_ready  consumer pop strobe (pop when valid & ready)
//   fifo_level  current FIFO occupancy
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 8
);
    logic [DATA_BITS-1:0]           data_out;
    logic                           data_valid;
    logic                           data_ready;
    logic [$clog2(FIFO_DEPTH):0]    fifo_level;

    modport master (
        output data_out,
        output data_valid,
        output fifo_level,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  fifo_level,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_sfifo.sv
// uart_rx_sfifo: generic synchronous first-word-fall-through FIFO.
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, din   write strobe and data; accepted when not full or popping
//   pop         read strobe; ignored when empty
//   dout        head word, '0 while empty
//   full, empty, level  occupancy status
module uart_rx_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with buffered FWFT output.
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx_data      serial input, idle high, asynchronous to clk
//   clk_div      clocks per bit, latched at start-bit detect (<2 treated as 2)
//   rx_if        FIFO handshake (data_out/data_valid/data_ready/fifo_level)
//   rx_active    frame in progress, START through STOP
//   frame_err    1-cycle pulse: stop bit sampled low
//   overrun      1-cycle pulse: good frame dropped because FIFO full
//   parity_err   1-cycle pulse: parity mismatch
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the
// data bits (PARITY_ODD selects odd sense); otherwise parity_err is tied 0.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_data,
    input  logic [DIV_W-1:0]  clk_div,
    uart_rx_fifo_if.master    rx_if,
    output logic              rx_active,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);
    localparam int unsigned IW = $clog2(DATA_BITS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state;
    logic [DIV_W-1:0]       cnt;
    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       div_eff;
    logic [DIV_W-1:0]       half_m1;
    logic [DIV_W-1:0]       full_m1;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   sr;
    logic                   bit_end;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   par_bad;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign div_eff   = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
    assign half_m1   = (div_q >> 1) - 1'b1;
    assign full_m1   = div_q - 1'b1;
    assign bit_end   = (cnt == full_m1);
    assign rx_active = (state != IDLE);
    assign pop       = rx_if.data_ready;
    // Push on the stop-sample edge itself so the word is visible the next cycle.
    assign push      = (state == STOP) && bit_end && rx_s && !par_bad;
    assign rx_if.data_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_data};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= (state == STOP) && bit_end && rx_s && par_bad;
            if (state == START) begin
                par_bad <= 1'b0;
            end else if (state == PARITY && bit_end) begin
                par_bad <= rx_s != ((^sr) ^ (PARITY_ODD != 0));
            end
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= DIV_W'(MIN_DIV);
            idx       <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // Full implies non-empty, so any ready pop makes room.
            overrun   <= push && fifo_full && !pop;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        div_q <= div_eff;
                    end
                end
                START: begin
                    if (cnt == half_m1) begin
                        state <= rx_s ? IDLE : DATA;
                        cnt   <= '0;
                        idx   <= '0;
                        sr    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        sr[idx] <= rx_s;
                        cnt     <= '0;
                        if (idx == IW'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        frame_err <= !rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_sfifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (sr),
        .pop   (pop),
        .dout  (rx_if.data_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (rx_if.fifo_level)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int unsigned DB    = 8;
    localparam int unsigned DIV   = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PODD  = 0;

    logic        clk;
    logic        rst_n;
    logic        rx_data;
    logic [15:0] clk_div;
    logic        rx_active;
    logic        frame_err;
    logic        overrun;
    logic        parity_err;

    uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) rx_if ();

    uart_rx_fifo #(
        .DATA_BITS  (DB),
        .DIV_W      (16),
        .FIFO_DEPTH (DEPTH),
        .PARITY_ODD (PODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .clk_div    (clk_div),
        .rx_if      (rx_if),
        .rx_active  (rx_active),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DB-1:0] sb [$];
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, act_cnt = 0, unexp_pops = 0;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: sample 2 time units after the falling edge, stable w.r.t. both edges.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (rx_active)  act_cnt++;
            if (rx_if.data_valid && rx_if.data_ready) begin
                if (sb.size() == 0) unexp_pops++;
                else check("pop_data", 32'(rx_if.data_out), 32'(sb.pop_front()));
            end
        end
    end

    // mode 0: plain; 1: ready high only for the stop-sample edge; 2: check push latency
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input logic bad_par, input int mode);
        if (!stop_bit) exp_fe++;
`ifdef UART_RX_PARITY_EN
        else if (bad_par) exp_pe++;
`endif
        else if (sb.size() < DEPTH || mode == 1) sb.push_back(d);
        else exp_ov++;
        @(negedge clk);
        rx_data = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_data = d[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_data = (^d) ^ (PODD != 0) ^ bad_par;
        repeat (DIV) @(negedge clk);
`endif
        rx_data = stop_bit;
        repeat (10) @(negedge clk);
        if (mode == 1) rx_if.data_ready = 1'b1;
        if (mode == 2) begin
            check("pre_stop_valid", 32'(rx_if.data_valid), 0);
            check("pre_stop_active", 32'(rx_active), 1);
        end
        @(negedge clk);
        if (mode == 1) rx_if.data_ready = 1'b0;
        if (mode == 2) begin
            check("lat_valid", 32'(rx_if.data_valid), 1);
            check("lat_data", 32'(rx_if.data_out), 32'(d));
            check("lat_level", 32'(rx_if.fifo_level), 1);
        end
        repeat (DIV - 11) @(negedge clk);
        rx_data = 1'b1;
    endtask

    initial begin
        int act0;
        rst_n = 1'b0;
        rx_data = 1'b1;
        clk_div = 16'(DIV);
        rx_if.data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_if.data_valid), 0);
        check("rst_level", 32'(rx_if.fifo_level), 0);
        check("rst_active", 32'(rx_active), 0);
        check("rst_data", 32'(rx_if.data_out), 0);
        check("rst_flags", 32'({frame_err, overrun, parity_err}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame, latency and level
        send_frame(8'hA5, 1'b1, 1'b0, 2);
        repeat (4) @(negedge clk);
        check("a5_level", 32'(rx_if.fifo_level), 1);
        rx_if.data_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("a5_drained", 32'(rx_if.fifo_level), 0);

        // Start glitch
        act0 = act_cnt;
        @(negedge clk);
        rx_data = 1'b0;
        repeat (4) @(negedge clk);
        rx_data = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_active_cycles", 32'(act_cnt - act0), 8);
        check("glitch_idle", 32'(rx_active), 0);
        check("glitch_level", 32'(rx_if.fifo_level), 0);
        check("glitch_fe", 32'(fe_cnt), 0);

        // Framing error
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        repeat (40) @(negedge clk);
        check("fe_count", 32'(fe_cnt), 32'(exp_fe));
        check("fe_level", 32'(rx_if.fifo_level), 0);

        // Overrun on 9th frame
        rx_if.data_ready = 1'b0;
        for (int i = 0; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
        repeat (4) @(negedge clk);
        check("ovr_level", 32'(rx_if.fifo_level), 8);
        check("ovr_count", 32'(ov_cnt), 32'(exp_ov));
        check("ovr_head_stable", 32'(rx_if.data_out), 0);
        rx_if.data_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("ovr_drained", 32'(rx_if.fifo_level), 0);
        check("ovr_sb_empty", 32'(sb.size()), 0);

        // Push and pop on a full FIFO in the same cycle
        rx_if.data_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 0);
        send_frame(8'h18, 1'b1, 1'b0, 1);
        repeat (4) @(negedge clk);
        check("pp_level", 32'(rx_if.fifo_level), 8);
        check("pp_no_ovr", 32'(ov_cnt), 32'(exp_ov));
        check("pp_head", 32'(rx_if.data_out), 32'h11);
        rx_if.data_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("pp_sb_empty", 32'(sb.size()), 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 0);
        repeat (4) @(negedge clk);
        check("par_count", 32'(pe_cnt), 32'(exp_pe));
        check("par_level", 32'(rx_if.fifo_level), 0);
`endif

        // Reset mid-frame
        rx_if.data_ready = 1'b0;
        send_frame(8'h42, 1'b1, 1'b0, 0);
        repeat (2) @(negedge clk);
        check("pre_rst_valid", 32'(rx_if.data_valid), 1);
        rx_data = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_data = (i % 2 == 0);
            repeat (DIV) @(negedge clk);
        end
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(rx_if.data_valid), 0);
        check("arst_level", 32'(rx_if.fifo_level), 0);
        check("arst_active", 32'(rx_active), 0);
        check("arst_data", 32'(rx_if.data_out), 0);
        sb.delete();
        rx_data = 1'b1;
        #20 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rx_if.data_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, 0);
        repeat (10) @(negedge clk);
        check("post_rst_sb_empty", 32'(sb.size()), 0);
        check("post_rst_level", 32'(rx_if.fifo_level), 0);

        check("final_fe", 32'(fe_cnt), 32'(exp_fe));
        check("final_ovr", 32'(ov_cnt), 32'(exp_ov));
        check("final_pe", 32'(pe_cnt), 32'(exp_pe));
        check("unexpected_pops", 32'(unexp_pops), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
